// File: rtl/g_regfile_sb_pkg.sv
// Shared parameters and index-decode helper for the g_regfile_sb register file.
// Provides default widths and a one-bit decode used to build per-register hit vectors.
package g_regfile_sb_pkg;

   localparam int W_OPR_D = 32;
   localparam int REG_N_D = 16;
   localparam int W_RD_D  = 4;
   localparam int N_WB_D  = 2;

   // Widest register index supported by the decode helper (REG_N <= 64).
   localparam int W_IDX_MAX = 6;

   // True when idx selects register r.
   function automatic logic idx_match(
      input logic [W_IDX_MAX-1:0] idx,
      input int                   r
   );
      return idx == W_IDX_MAX'(r);
   endfunction

endpackage

// File: rtl/g_regfile_sb_if.sv
// Issue / operand / write-back bundle of the g_regfile_sb register file.
// slave: the register file; master: decode/issue and write-back drivers.
interface g_regfile_sb_if
   import g_regfile_sb_pkg::*;
#(
   parameter int W_OPR = W_OPR_D,
   parameter int REG_N = REG_N_D,
   parameter int W_RD  = W_RD_D,
   parameter int N_WB  = N_WB_D
);

   logic [W_RD-1:0]       r0_i;
   logic                  r0_v_i;
   logic [W_RD-1:0]       r1_i;
   logic                  r1_v_i;
   logic [W_RD-1:0]       rd_i;
   logic                  w_reserve_i;
   logic [W_OPR-1:0]      r_opr0_o;
   logic [W_OPR-1:0]      r_opr1_o;
   logic                  reserved_o;
   logic                  issued_o;
   logic [N_WB-1:0]       wb_i;
   logic [N_WB*W_RD-1:0]  wb_r_i;
   logic [N_WB*W_OPR-1:0] result_i;
   logic                  flush_i;
   logic [REG_N-1:0]      busy_o;

   modport slave (
      input  r0_i, r0_v_i, r1_i, r1_v_i, rd_i, w_reserve_i,
      input  wb_i, wb_r_i, result_i, flush_i,
      output r_opr0_o, r_opr1_o, reserved_o, issued_o, busy_o
   );

   modport master (
      output r0_i, r0_v_i, r1_i, r1_v_i, rd_i, w_reserve_i,
      output wb_i, wb_r_i, result_i, flush_i,
      input  r_opr0_o, r_opr1_o, reserved_o, issued_o, busy_o
   );

endinterface

// File: rtl/g_reg_entry.sv
// One general register: data word plus write-reservation (busy) bit.
// Ports: clk, rst (async, active low), we/wdata, set_busy, clr_busy, flush -> data, busy.
module g_reg_entry
   import g_regfile_sb_pkg::*;
#(
   parameter int W_OPR = W_OPR_D
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [W_OPR-1:0] wdata,
   input  logic             set_busy,
   input  logic             clr_busy,
   input  logic             flush,
   output logic [W_OPR-1:0] data,
   output logic             busy
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data <= '0;
         busy <= 1'b0;
      end else begin
         if (we) data <= wdata;
         // flush beats a new reservation, which beats a write-back clear
         if (flush)         busy <= 1'b0;
         else if (set_busy) busy <= 1'b1;
         else if (clr_busy) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/g_regfile_sb.sv
// General register file with write-reservation scoreboard and write-back bypass.
// Ports: clk, rst (async, active low), bus (g_regfile_sb_if.slave: operands, issue, write-back, busy).
module g_regfile_sb
   import g_regfile_sb_pkg::*;
#(
   parameter int W_OPR   = W_OPR_D,
   parameter int REG_N   = REG_N_D,
   parameter int W_RD    = W_RD_D,
   parameter int N_WB    = N_WB_D,
   parameter int ZERO_R0 = 0
) (
   input  logic           clk,
   input  logic           rst,
   g_regfile_sb_if.slave  bus
);

   logic [W_OPR-1:0] data_q [REG_N];
   logic [REG_N-1:0] busy_q;

   logic [W_RD-1:0]  wb_idx [N_WB];
   logic [W_OPR-1:0] wb_dat [N_WB];
   logic [REG_N-1:0] wb_hot [N_WB];
   logic [REG_N-1:0] wb_hit;
   logic [W_OPR-1:0] wdata  [REG_N];

   logic [REG_N-1:0] z0_mask;
   logic [REG_N-1:0] we;
   logic [REG_N-1:0] rd_hot;
   logic [REG_N-1:0] set_b;

   logic [W_RD-1:0]  ridx [3];
   logic [W_OPR-1:0] ropr [2];
   logic [2:0]       pend;
   logic             reserved;
   logic             issued;

   // r0 hard-wired to zero: never written, never reserved
   assign z0_mask = (ZERO_R0 != 0) ? REG_N'(1) : '0;

   always_comb begin
      for (int k = 0; k < N_WB; k++) begin
         wb_idx[k] = bus.wb_r_i[k*W_RD +: W_RD];
         wb_dat[k] = bus.result_i[k*W_OPR +: W_OPR];
         wb_hot[k] = '0;
         for (int r = 0; r < REG_N; r++) begin
            wb_hot[k][r] = bus.wb_i[k]
               & idx_match(W_IDX_MAX'(wb_idx[k]), r);
         end
      end
   end

   // ascending port loop: the highest matching port wins
   always_comb begin
      for (int r = 0; r < REG_N; r++) begin
         wb_hit[r] = 1'b0;
         wdata[r]  = '0;
         for (int k = 0; k < N_WB; k++) begin
            if (wb_hot[k][r]) begin
               wb_hit[r] = 1'b1;
               wdata[r]  = wb_dat[k];
            end
         end
      end
   end

   always_comb begin
      ridx[0] = bus.r0_i;
      ridx[1] = bus.r1_i;
      ridx[2] = bus.rd_i;
      for (int p = 0; p < 2; p++) begin
         ropr[p] = data_q[ridx[p]];
         for (int k = 0; k < N_WB; k++) begin
            if (wb_hot[k][ridx[p]]) ropr[p] = wb_dat[k];
         end
         if (ZERO_R0 != 0 && ridx[p] == '0) ropr[p] = '0;
      end
      for (int p = 0; p < 3; p++) begin
         // a write-back landing this cycle releases the reservation
         pend[p] = busy_q[ridx[p]] & ~wb_hit[ridx[p]];
         if (ZERO_R0 != 0 && ridx[p] == '0) pend[p] = 1'b0;
      end
   end

   always_comb begin
      for (int r = 0; r < REG_N; r++) begin
         rd_hot[r] = idx_match(W_IDX_MAX'(bus.rd_i), r);
      end
   end

   assign reserved = (bus.r0_v_i & pend[0])
                   | (bus.r1_v_i & pend[1])
                   | (bus.w_reserve_i & pend[2]);
   assign issued   = bus.w_reserve_i & ~reserved & ~bus.flush_i;

   assign we    = wb_hit & ~z0_mask;
   assign set_b = issued ? (rd_hot & ~z0_mask) : '0;

   for (genvar r = 0; r < REG_N; r++) begin : g_ent
      g_reg_entry #(
         .W_OPR (W_OPR)
      ) u_ent (
         .clk      (clk),
         .rst      (rst),
         .we       (we[r]),
         .wdata    (wdata[r]),
         .set_busy (set_b[r]),
         .clr_busy (we[r]),
         .flush    (bus.flush_i),
         .data     (data_q[r]),
         .busy     (busy_q[r])
      );
   end

   assign bus.r_opr0_o   = ropr[0];
   assign bus.r_opr1_o   = ropr[1];
   assign bus.reserved_o = reserved;
   assign bus.issued_o   = issued;
   assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_g_regfile_sb.sv
// Directed bench for g_regfile_sb: vector table plus reset and ZERO_R0 sequences.
// Two instances: ZERO_R0=0 (main) and ZERO_R0=1 (r0 tie-off).
module tb_g_regfile_sb;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   g_regfile_sb_if #(.W_OPR(32), .REG_N(16), .W_RD(4), .N_WB(2)) b0 ();
   g_regfile_sb_if #(.W_OPR(32), .REG_N(16), .W_RD(4), .N_WB(2)) b1 ();

   g_regfile_sb #(
      .W_OPR(32), .REG_N(16), .W_RD(4), .N_WB(2), .ZERO_R0(0)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (b0.slave)
   );

   g_regfile_sb #(
      .W_OPR(32), .REG_N(16), .W_RD(4), .N_WB(2), .ZERO_R0(1)
   ) u_dz (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   typedef struct {
      logic [3:0]  r0;
      logic        r0v;
      logic [3:0]  r1;
      logic        r1v;
      logic [3:0]  rd;
      logic        wres;
      logic [1:0]  wb;
      logic [3:0]  wr0;
      logic [3:0]  wr1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        fl;
      logic [31:0] eo0;
      logic [31:0] eo1;
      logic        eres;
      logic        eiss;
      logic [15:0] ebusy;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic idle0();
      b0.r0_i = '0; b0.r0_v_i = 1'b0;
      b0.r1_i = '0; b0.r1_v_i = 1'b0;
      b0.rd_i = '0; b0.w_reserve_i = 1'b0;
      b0.wb_i = '0; b0.wb_r_i = '0;
      b0.result_i = '0; b0.flush_i = 1'b0;
   endtask

   task automatic idle1();
      b1.r0_i = '0; b1.r0_v_i = 1'b0;
      b1.r1_i = '0; b1.r1_v_i = 1'b0;
      b1.rd_i = '0; b1.w_reserve_i = 1'b0;
      b1.wb_i = '0; b1.wb_r_i = '0;
      b1.result_i = '0; b1.flush_i = 1'b0;
   endtask

   // called at posedge+1; checks combinational outputs mid-cycle,
   // then busy_o after the edge
   task automatic apply(input int i, input vec_t v);
      b0.r0_i = v.r0; b0.r0_v_i = v.r0v;
      b0.r1_i = v.r1; b0.r1_v_i = v.r1v;
      b0.rd_i = v.rd; b0.w_reserve_i = v.wres;
      b0.wb_i = v.wb; b0.wb_r_i = {v.wr1, v.wr0};
      b0.result_i = {v.d1, v.d0}; b0.flush_i = v.fl;
      #3;
      chk($sformatf("v%0d opr0", i), b0.r_opr0_o, v.eo0);
      chk($sformatf("v%0d opr1", i), b0.r_opr1_o, v.eo1);
      chk($sformatf("v%0d reserved", i), 32'(b0.reserved_o), 32'(v.eres));
      chk($sformatf("v%0d issued", i), 32'(b0.issued_o), 32'(v.eiss));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d busy", i), 32'(b0.busy_o), 32'(v.ebusy));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      //          r0  v    r1  v    rd  res   wb    wr0   wr1   d0            d1            fl    eo0           eo1           res   iss   busy
      tbl[0]  = '{4'd1,1'b1,4'd2,1'b1,4'd0,1'b0,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b0,16'h0000};
      tbl[1]  = '{4'd0,1'b0,4'd0,1'b0,4'd3,1'b1,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b1,16'h0008};
      tbl[2]  = '{4'd3,1'b1,4'd0,1'b0,4'd0,1'b0,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'h0,32'h0,1'b1,1'b0,16'h0008};
      tbl[3]  = '{4'd3,1'b1,4'd0,1'b0,4'd0,1'b0,2'b01,4'd3,4'd0,32'hDEADBEEF,32'h0,1'b0,32'hDEADBEEF,32'h0,1'b0,1'b0,16'h0000};
      tbl[4]  = '{4'd3,1'b1,4'd5,1'b0,4'd5,1'b1,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'hDEADBEEF,32'h0,1'b0,1'b1,16'h0020};
      tbl[5]  = '{4'd3,1'b1,4'd5,1'b1,4'd0,1'b0,2'b11,4'd5,4'd5,32'h1,32'h2,1'b0,32'hDEADBEEF,32'h2,1'b0,1'b0,16'h0000};
      tbl[6]  = '{4'd3,1'b1,4'd5,1'b1,4'd7,1'b1,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'hDEADBEEF,32'h2,1'b0,1'b1,16'h0080};
      tbl[7]  = '{4'd7,1'b1,4'd5,1'b1,4'd7,1'b1,2'b10,4'd0,4'd7,32'h0,32'hA5A50007,1'b0,32'hA5A50007,32'h2,1'b0,1'b1,16'h0080};
      tbl[8]  = '{4'd7,1'b0,4'd5,1'b1,4'd7,1'b1,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'hA5A50007,32'h2,1'b1,1'b0,16'h0080};
      tbl[9]  = '{4'd0,1'b0,4'd0,1'b0,4'd2,1'b1,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b1,16'h0084};
      tbl[10] = '{4'd0,1'b0,4'd0,1'b0,4'd9,1'b1,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b1,16'h0284};
      tbl[11] = '{4'd0,1'b0,4'd0,1'b0,4'd12,1'b1,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b1,16'h1284};
      tbl[12] = '{4'd2,1'b1,4'd0,1'b0,4'd4,1'b1,2'b01,4'd2,4'd0,32'h22,32'h0,1'b1,32'h22,32'h0,1'b0,1'b0,16'h0000};
      tbl[13] = '{4'd2,1'b1,4'd12,1'b1,4'd0,1'b0,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'h22,32'h0,1'b0,1'b0,16'h0000};
      tbl[14] = '{4'd8,1'b1,4'd9,1'b1,4'd0,1'b0,2'b11,4'd8,4'd9,32'h11,32'h99,1'b0,32'h11,32'h99,1'b0,1'b0,16'h0000};
      tbl[15] = '{4'd8,1'b1,4'd9,1'b1,4'd0,1'b0,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'h11,32'h99,1'b0,1'b0,16'h0000};
      tbl[16] = '{4'd0,1'b0,4'd0,1'b0,4'd10,1'b1,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b1,16'h0400};
      tbl[17] = '{4'd10,1'b0,4'd10,1'b1,4'd0,1'b0,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'h0,32'h0,1'b1,1'b0,16'h0400};
      tbl[18] = '{4'd10,1'b0,4'd10,1'b0,4'd0,1'b0,2'b00,4'd0,4'd0,32'h0,32'h0,1'b0,32'h0,32'h0,1'b0,1'b0,16'h0400};

      rst = 1'b0;
      idle0();
      idle1();
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", 32'(b0.busy_o), 32'h0);
      chk("rst opr0", b0.r_opr0_o, 32'h0);
      chk("rst reserved", 32'(b0.reserved_o), 32'h0);
      chk("rst z busy", 32'(b1.busy_o), 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         apply(i, tbl[i]);
      end

      // async reset mid-cycle with r10 reserved and r3 holding data
      idle0();
      b0.r0_i = 4'd3; b0.r0_v_i = 1'b1;
      b0.r1_i = 4'd10; b0.r1_v_i = 1'b1;
      #1;
      chk("pre-rst opr0", b0.r_opr0_o, 32'hDEADBEEF);
      chk("pre-rst reserved", 32'(b0.reserved_o), 32'h1);
      rst = 1'b0;
      #1;
      chk("mid-rst busy", 32'(b0.busy_o), 32'h0);
      chk("mid-rst opr0", b0.r_opr0_o, 32'h0);
      chk("mid-rst opr1", b0.r_opr1_o, 32'h0);
      chk("mid-rst reserved", 32'(b0.reserved_o), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post-rst opr0", b0.r_opr0_o, 32'h0);
      chk("post-rst busy", 32'(b0.busy_o), 32'h0);

      // ZERO_R0: write and reservation of r0 are dropped
      b1.wb_i = 2'b01;
      b1.wb_r_i = {4'd0, 4'd0};
      b1.result_i = {32'h0, 32'h0000FFFF};
      b1.w_reserve_i = 1'b1; b1.rd_i = 4'd0;
      b1.r0_i = 4'd0; b1.r0_v_i = 1'b1;
      b1.r1_i = 4'd0; b1.r1_v_i = 1'b1;
      #3;
      chk("z opr0", b1.r_opr0_o, 32'h0);
      chk("z opr1", b1.r_opr1_o, 32'h0);
      chk("z reserved", 32'(b1.reserved_o), 32'h0);
      chk("z issued", 32'(b1.issued_o), 32'h1);
      @(posedge clk);
      #1;
      chk("z busy", 32'(b1.busy_o), 32'h0);
      chk("z opr0 after", b1.r_opr0_o, 32'h0);

      // r1 on the same instance behaves normally; set beats wb clear
      b1.wb_i = 2'b10;
      b1.wb_r_i = {4'd1, 4'd0};
      b1.result_i = {32'h00001234, 32'h0};
      b1.rd_i = 4'd1; b1.w_reserve_i = 1'b1;
      b1.r0_i = 4'd1; b1.r0_v_i = 1'b1;
      b1.r1_v_i = 1'b0;
      #3;
      chk("z r1 bypass", b1.r_opr0_o, 32'h00001234);
      chk("z r1 issued", 32'(b1.issued_o), 32'h1);
      @(posedge clk);
      #1;
      idle1();
      b1.r0_i = 4'd1; b1.r0_v_i = 1'b1;
      #1;
      chk("z r1 busy", 32'(b1.busy_o), 32'h0002);
      chk("z r1 data", b1.r_opr0_o, 32'h00001234);
      chk("z r1 reserved", 32'(b1.reserved_o), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
